// File: rtl/dds_phase_diff.sv
`default_nettype none
// ============================================================================
// Module   : dds_phase_diff
// Brief    : Recovers the DDS frequency word from a stream of phase-accumulator
//            samples. Averages 2^AVG_LOG2 modular first differences and counts
//            accumulator wrap events per window.
//            Optional macro DDS_PHASE_DIFF_STABLE_EN adds stable_o, which flags
//            that consecutive window averages agree within STABLE_TOL.
// Revision : 1.0 - initial release
// ============================================================================
module dds_phase_diff #(
  parameter int PHASE_ACC_WIDTH = 16,
  parameter int PHASE_INC_WIDTH = 16,
  parameter int AVG_LOG2        = 2
`ifdef DDS_PHASE_DIFF_STABLE_EN
  ,
  parameter int STABLE_TOL      = 1
`endif
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [PHASE_ACC_WIDTH-1:0] phase_i,
  input  logic                       phase_vld_i,
  input  logic                       clear_i,
  output logic [PHASE_INC_WIDTH-1:0] phase_inc_o,
  output logic                       phase_inc_vld_o,
  output logic [AVG_LOG2:0]          wrap_cnt_o,
  output logic                       overrange_o,
  output logic                       busy_o
`ifdef DDS_PHASE_DIFF_STABLE_EN
  ,
  output logic                       stable_o
`endif
);

  localparam int SUM_W = PHASE_ACC_WIDTH + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [PHASE_ACC_WIDTH-1:0] prev_q, prev_d;
  logic [SUM_W-1:0]           sum_q, sum_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CNT_W-1:0]           wrap_q, wrap_d;
  logic [PHASE_INC_WIDTH-1:0] inc_q, inc_d;
  logic                       vld_q, vld_d;
  logic [CNT_W-1:0]           wrap_out_q, wrap_out_d;
  logic                       ovr_q, ovr_d;

  logic [PHASE_ACC_WIDTH-1:0] diff_w;
  logic [SUM_W-1:0]           sum_next_w;
  logic [CNT_W-1:0]           wrap_next_w;
  logic [PHASE_ACC_WIDTH-1:0] avg_w;
  logic                       ovr_w;

`ifdef DDS_PHASE_DIFF_STABLE_EN
  logic [PHASE_ACC_WIDTH-1:0] prev_avg_q, prev_avg_d;
  logic                       first_q, first_d;
  logic                       stable_q, stable_d;
  logic [PHASE_ACC_WIDTH-1:0] abs_diff_w;
`endif

  // Datapath for the sample currently offered: modular difference, running
  // sum, wrap count and the window average it would produce.
  always_comb begin
    diff_w      = phase_i - prev_q;
    sum_next_w  = sum_q + SUM_W'(diff_w);
    wrap_next_w = wrap_q + CNT_W'(phase_i < prev_q);
    avg_w       = PHASE_ACC_WIDTH'(sum_next_w >> AVG_LOG2);
  end

  // Upper average bits that do not fit the output width flag overrange.
  generate
    if (PHASE_INC_WIDTH < PHASE_ACC_WIDTH) begin : g_ovr_narrow
      assign ovr_w = |avg_w[PHASE_ACC_WIDTH-1:PHASE_INC_WIDTH];
    end else begin : g_ovr_full
      assign ovr_w = 1'b0;
    end
  endgenerate

`ifdef DDS_PHASE_DIFF_STABLE_EN
  // Distance between this window's average and the previous one.
  always_comb begin
    abs_diff_w = (avg_w >= prev_avg_q) ? (avg_w - prev_avg_q) : (prev_avg_q - avg_w);
  end
`endif

  // Next-state logic: clear wins over a sample; a completing sample publishes
  // the result and restarts accumulation while keeping prev as reference.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    wrap_d     = wrap_q;
    inc_d      = inc_q;
    vld_d      = 1'b0;
    wrap_out_d = wrap_out_q;
    ovr_d      = ovr_q;
`ifdef DDS_PHASE_DIFF_STABLE_EN
    prev_avg_d = prev_avg_q;
    first_d    = first_q;
    stable_d   = stable_q;
`endif
    if (clear_i) begin
      state_d = ST_EMPTY;
      sum_d   = '0;
      cnt_d   = '0;
      wrap_d  = '0;
`ifdef DDS_PHASE_DIFF_STABLE_EN
      first_d  = 1'b1;
      stable_d = 1'b0;
`endif
    end else if (phase_vld_i) begin
      case (state_q)
        ST_EMPTY: begin
          prev_d  = phase_i;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          prev_d = phase_i;
          if (cnt_q == C_LAST_CNT) begin
            inc_d      = avg_w[PHASE_INC_WIDTH-1:0];
            ovr_d      = ovr_w;
            wrap_out_d = wrap_next_w;
            vld_d      = 1'b1;
            sum_d      = '0;
            cnt_d      = '0;
            wrap_d     = '0;
`ifdef DDS_PHASE_DIFF_STABLE_EN
            stable_d   = !first_q && (abs_diff_w <= PHASE_ACC_WIDTH'(STABLE_TOL));
            first_d    = 1'b0;
            prev_avg_d = avg_w;
`endif
          end else begin
            sum_d  = sum_next_w;
            cnt_d  = cnt_q + 1'b1;
            wrap_d = wrap_next_w;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      prev_q     <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      wrap_q     <= '0;
      inc_q      <= '0;
      vld_q      <= 1'b0;
      wrap_out_q <= '0;
      ovr_q      <= 1'b0;
`ifdef DDS_PHASE_DIFF_STABLE_EN
      prev_avg_q <= '0;
      first_q    <= 1'b1;
      stable_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      inc_q      <= inc_d;
      vld_q      <= vld_d;
      wrap_out_q <= wrap_out_d;
      ovr_q      <= ovr_d;
`ifdef DDS_PHASE_DIFF_STABLE_EN
      prev_avg_q <= prev_avg_d;
      first_q    <= first_d;
      stable_q   <= stable_d;
`endif
    end
  end

  assign phase_inc_o     = inc_q;
  assign phase_inc_vld_o = vld_q;
  assign wrap_cnt_o      = wrap_out_q;
  assign overrange_o     = ovr_q;
  assign busy_o          = (state_q == ST_RUN);
`ifdef DDS_PHASE_DIFF_STABLE_EN
  assign stable_o        = stable_q;
`endif

endmodule
`default_nettype wire
